// File: rtl/varredura_matriz_pkg.sv
// rtl/varredura_matriz_pkg.sv - shared FSM encoding and width helpers for the LED row scanner
// Contents:
//   estado_t       scan FSM states (IDLE, BLANK, LOAD, SHOW)
//   largura_dwell  width of the dwell counter, wide enough for both DIV and BLANK_CYC
//   limite_pwm     number of SHOW cycles with columns driven for a given brilho (min 1)
package varredura_matriz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHOW  = 2'd3
    } estado_t;

    function automatic int largura_dwell(input int div, input int blank_cyc);
        int maior;
        maior = (div > blank_cyc) ? div : blank_cyc;
        return $clog2(maior + 1);
    endfunction

    function automatic int limite_pwm(input int brilho, input int div);
        int v;
        v = ((brilho + 1) * div) / 8;
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/varredura_matriz_temporizador_linha.sv
// rtl/varredura_matriz_temporizador_linha.sv - loadable down-counter timing BLANK and SHOW dwell
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   limpa         synchronous clear (scan disabled)
//   inicia        load comprimento into the counter
//   comprimento   dwell length in cycles (>=1)
//   restante      cycles left in the current dwell, comprimento on its first cycle
//   fim           high on the last cycle of the dwell (restante == 1)
module temporizador_linha #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         limpa,
    input  logic         inicia,
    input  logic [W-1:0] comprimento,
    output logic [W-1:0] restante,
    output logic         fim
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restante <= '0;
        end else if (limpa) begin
            restante <= '0;
        end else if (inicia) begin
            restante <= comprimento;
        end else if (restante != '0) begin
            restante <= restante - W'(1);
        end
    end

    assign fim = (restante == W'(1));

endmodule

// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - row-scan sequencer for the 5x7 LED matrix with inter-row blanking
// Optional feature macro: VARREDURA_PWM_EN (adds brilho port, per-row column duty limit).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   habilita      1 = scan runs, 0 = dark and parked at row 0
//   brilho        duty select, sampled in LOAD (VARREDURA_PWM_EN only)
//   colunas       active-high column pattern for contador, from the pattern source
//   contador      row index fed to the pattern source
//   linhas_out    one-hot active-high row drive
//   colunas_out   active-low column drive
//   fim_quadro    1-cycle pulse as the last row ends and contador wraps to 0
module varredura_matriz
    import varredura_matriz_pkg::*;
#(
    parameter int LINHAS    = 7,
    parameter int COLUNAS   = 5,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       habilita,
`ifdef VARREDURA_PWM_EN
    input  logic [2:0]                 brilho,
`endif
    input  logic [COLUNAS-1:0]         colunas,
    output logic [$clog2(LINHAS)-1:0]  contador,
    output logic [LINHAS-1:0]          linhas_out,
    output logic [COLUNAS-1:0]         colunas_out,
    output logic                       fim_quadro
);

    localparam int CW = $clog2(LINHAS);
    localparam int DW = largura_dwell(DIV, BLANK_CYC);

    estado_t            estado;
    logic [COLUNAS-1:0] padrao;
    logic               inicia;
    logic [DW-1:0]      comprimento;
    logic [DW-1:0]      restante;
    logic               fim_dwell;
    logic [DW-1:0]      limite;

    temporizador_linha #(.W(DW)) u_temporizador (
        .clk         (clk),
        .rst_n       (rst_n),
        .limpa       (!habilita),
        .inicia      (inicia),
        .comprimento (comprimento),
        .restante    (restante),
        .fim         (fim_dwell)
    );

    // One timer serves both dwells: it is armed with BLANK_CYC on every entry to
    // BLANK and with DIV on the LOAD->SHOW step; LOAD itself is a fixed single cycle.
    always_comb begin
        inicia      = 1'b0;
        comprimento = DW'(BLANK_CYC);
        if (habilita) begin
            case (estado)
                ST_IDLE: inicia = 1'b1;
                ST_LOAD: begin
                    inicia      = 1'b1;
                    comprimento = DW'(DIV);
                end
                ST_SHOW: inicia = fim_dwell;
                default: inicia = 1'b0;
            endcase
        end
    end

`ifndef VARREDURA_PWM_EN
    // Without duty control the columns stay driven for the whole dwell.
    assign limite = DW'(DIV);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= ST_IDLE;
            contador    <= '0;
            linhas_out  <= '0;
            colunas_out <= '1;
            fim_quadro  <= 1'b0;
            padrao      <= '0;
`ifdef VARREDURA_PWM_EN
            limite      <= '0;
`endif
        end else begin
            fim_quadro <= 1'b0;
            if (!habilita) begin
                estado      <= ST_IDLE;
                contador    <= '0;
                linhas_out  <= '0;
                colunas_out <= '1;
            end else begin
                case (estado)
                    ST_IDLE: estado <= ST_BLANK;
                    ST_BLANK: begin
                        if (fim_dwell) begin
                            estado <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        padrao      <= colunas;
                        linhas_out  <= LINHAS'(1) << contador;
                        colunas_out <= ~colunas;
                        estado      <= ST_SHOW;
`ifdef VARREDURA_PWM_EN
                        limite      <= DW'(limite_pwm(int'(brilho), DIV));
`endif
                    end
                    ST_SHOW: begin
                        if (fim_dwell) begin
                            estado      <= ST_BLANK;
                            linhas_out  <= '0;
                            colunas_out <= '1;
                            if (contador == CW'(LINHAS - 1)) begin
                                contador   <= '0;
                                fim_quadro <= 1'b1;
                            end else begin
                                contador <= contador + CW'(1);
                            end
                        end else if (int'(restante) > DIV + 1 - int'(limite)) begin
                            // The current SHOW cycle is DIV-restante+1; keep columns on
                            // for the next cycle only while it stays within the limit.
                            colunas_out <= ~padrao;
                        end else begin
                            colunas_out <= '1;
                        end
                    end
                    default: estado <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// tb/tb_varredura_matriz.sv - scoreboard bench for the LED matrix row scanner
module tb_varredura_matriz;

    localparam int LINHAS    = 7;
    localparam int COLUNAS   = 5;
    localparam int BLANK_CYC = 2;
`ifdef VARREDURA_PWM_EN
    localparam int DIV       = 8;
`else
    localparam int DIV       = 4;
`endif
    localparam int ESCURO    = BLANK_CYC + 1;
    localparam int QUADRO    = LINHAS * (ESCURO + DIV);
    localparam int ESPERA    = 200;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       habilita = 1'b0;
    logic [2:0]                 brilho = 3'd7;
    logic [COLUNAS-1:0]         colunas;
    logic [$clog2(LINHAS)-1:0]  contador;
    logic [LINHAS-1:0]          linhas_out;
    logic [COLUNAS-1:0]         colunas_out;
    logic                       fim_quadro;

    typedef struct {
        int                 linha;
        logic [COLUNAS-1:0] pad;
        int                 acionados;
    } item_t;

    item_t fila[$];
    int    fim_ciclos[$];
    int    fim_cont[$];
    int    checks = 0;
    int    erros  = 0;
    int    ciclo  = 0;

    varredura_matriz #(
        .LINHAS    (LINHAS),
        .COLUNAS   (COLUNAS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .habilita    (habilita),
`ifdef VARREDURA_PWM_EN
        .brilho      (brilho),
`endif
        .colunas     (colunas),
        .contador    (contador),
        .linhas_out  (linhas_out),
        .colunas_out (colunas_out),
        .fim_quadro  (fim_quadro)
    );

    always #5 clk = ~clk;

    function automatic logic [COLUNAS-1:0] padrao_linha(input int r);
        case (r)
            0:       return 5'b10001;
            1:       return 5'b01010;
            2:       return 5'b00100;
            3:       return 5'b11111;
            4:       return 5'b10101;
            5:       return 5'b01110;
            6:       return 5'b00011;
            default: return 5'b01011;
        endcase
    endfunction

    assign colunas = padrao_linha(int'(contador));

    always @(negedge clk) begin
        ciclo++;
        if (fim_quadro) begin
            fim_ciclos.push_back(ciclo);
            fim_cont.push_back(int'(contador));
        end
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            erros++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic empilha(input int r, input int n);
        item_t it;
        it.linha     = r;
        it.pad       = padrao_linha(r);
        it.acionados = n;
        fila.push_back(it);
    endtask

    // Called at the negedge of the first dark cycle before a row.
    task automatic observa_linha();
        item_t              it;
        int                 escuros;
        int                 acesos;
        int                 acionados;
        int                 desvios;
        logic [LINHAS-1:0]  esp_lin;
        logic [COLUNAS-1:0] esp_col;
        if (fila.size() == 0) begin
            erros++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
            return;
        end
        it      = fila.pop_front();
        esp_lin = LINHAS'(1) << it.linha;
        esp_col = ~it.pad;
        escuros = 0;
        while (linhas_out == '0 && escuros < ESPERA) begin
            escuros++;
            @(negedge clk);
        end
        verifica("dark_before_row", escuros, ESCURO);
        verifica("row_drive", linhas_out, esp_lin);
        verifica("row_index", contador, it.linha);
        verifica("col_drive", colunas_out, esp_col);
        acesos    = 0;
        acionados = 0;
        desvios   = 0;
        while (linhas_out != '0 && acesos < ESPERA) begin
            if (linhas_out !== esp_lin) desvios++;
            if (colunas_out !== '1) begin
                acionados++;
                if (colunas_out !== esp_col) desvios++;
            end
            acesos++;
            @(negedge clk);
        end
        verifica("lit_cycles", acesos, DIV);
        verifica("driven_cycles", acionados, it.acionados);
        verifica("row_stable", desvios, 0);
    endtask

    initial begin
        int n;

        // 1: asynchronous reset with no clock edge yet
        #1 rst_n = 1'b0;
        #1;
        verifica("rst_rows", linhas_out, 0);
        verifica("rst_cols", colunas_out, 5'b11111);
        verifica("rst_index", contador, 0);
        verifica("rst_frame", fim_quadro, 0);

        // 2/3: two full frames in row order
        @(negedge clk);
        rst_n    = 1'b1;
        habilita = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < LINHAS; r++) empilha(r, DIV);
        for (int k = 0; k < 2 * LINHAS; k++) observa_linha();

        // 4: disable during SHOW of row 3, then re-enable
        for (int r = 0; r < 3; r++) empilha(r, DIV);
        for (int k = 0; k < 3; k++) observa_linha();
        n = 0;
        while (linhas_out == '0 && n < ESPERA) begin
            n++;
            @(negedge clk);
        end
        verifica("row3_lit", linhas_out, 7'b0001000);
        habilita = 1'b0;
        @(negedge clk);
        verifica("off_rows", linhas_out, 0);
        verifica("off_cols", colunas_out, 5'b11111);
        verifica("off_index", contador, 0);
        repeat (3) @(negedge clk);
        verifica("off_parked", linhas_out, 0);

        verifica("frame_pulses", fim_ciclos.size(), 2);
        if (fim_ciclos.size() >= 2) begin
            verifica("frame_period", fim_ciclos[1] - fim_ciclos[0], QUADRO);
            verifica("frame_wrap0", fim_cont[0], 0);
            verifica("frame_wrap1", fim_cont[1], 0);
        end

        habilita = 1'b1;
        @(negedge clk);
        empilha(0, DIV);
        observa_linha();

        // 5: reset pulse mid-SHOW of row 1
        n = 0;
        while (linhas_out == '0 && n < ESPERA) begin
            n++;
            @(negedge clk);
        end
        verifica("row1_lit", linhas_out, 7'b0000010);
        rst_n = 1'b0;
        #1;
        verifica("mid_rst_rows", linhas_out, 0);
        verifica("mid_rst_cols", colunas_out, 5'b11111);
        verifica("mid_rst_index", contador, 0);
        verifica("mid_rst_frame", fim_quadro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        empilha(0, DIV);
        empilha(1, DIV);
        observa_linha();
        observa_linha();

`ifdef VARREDURA_PWM_EN
        // 6: duty limit per row, brilho sampled in LOAD
        brilho = 3'd3;
        empilha(2, 4);
        observa_linha();
        brilho = 3'd7;
        empilha(3, 8);
        observa_linha();
        brilho = 3'd0;
        empilha(4, 1);
        observa_linha();
`endif

        verifica("scoreboard_drained", fila.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, erros);
        $finish;
    end

endmodule
